// File: rtl/maple_pkg.sv
// Shared definitions for the maple sparse-MAC row scheduler: FSM state
// codes, default geometry and the signed accumulator clamp limit.
package maple_pkg;

    localparam int DEF_K        = 4;
    localparam int DEF_ACC_W    = 28;
    localparam int DEF_ROW_W    = 16;
    localparam int DEF_INFLIGHT = 4;
    localparam int DEF_OUT      = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Largest positive value of a w-bit signed accumulator; the negative
    // limit is its bitwise complement.
    function automatic longint acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/maple_sync_fifo.sv
// Small synchronous FIFO with occupancy count. A push while full is
// accepted when a pop happens in the same cycle.
module maple_sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    // Qualify push/pop against the current occupancy.
    always_comb begin
        rd_en_s = pop && (count_r != {CW{1'b0}});
        wr_en_s = push && ((count_r != CW'(DEPTH)) || pop);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;

endmodule

// File: rtl/maple_row_scheduler.sv
// Row scheduler for the 4-level sparse MAC pipeline: issues compressed
// chunks to the datapath, tracks them in a tag FIFO, accumulates the
// returning partial sums per row and buffers the saturated row results.
module maple_row_scheduler
    import maple_pkg::*;
#(
    parameter int K            = DEF_K,
    parameter int ACC_W        = DEF_ACC_W,
    parameter int MAX_INFLIGHT = DEF_INFLIGHT,
    parameter int ROW_W        = DEF_ROW_W,
    parameter int OUT_DEPTH    = DEF_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             chunk_valid,
    output logic             chunk_ready,
    input  logic [8*K-1:0]   chunk_mat,
    input  logic [8*K-1:0]   chunk_vec,
    input  logic [K-1:0]     chunk_ipv,
    input  logic             chunk_last,
    output logic             dp_valid,
    output logic [8*K-1:0]   dp_mat,
    output logic [8*K-1:0]   dp_vec,
    output logic [K-1:0]     dp_ipv,
    input  logic             psum_valid,
    input  logic [ACC_W-1:0] psum,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [ACC_W-1:0] row_data,
    output logic [ROW_W-1:0] row_idx,
    output logic             row_sat,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TCW = $clog2(MAX_INFLIGHT + 1);
    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam int OW  = ACC_W + ROW_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    logic [1:0]       state_r, state_nxt_s;
    logic [ROW_W-1:0] num_rows_r, issue_row_r, ret_row_r, emit_r;
    logic [ACC_W-1:0] acc_r;
    logic             sat_r, err_r;
    logic [TCW-1:0]   rif_r, tag_count_s;
    logic [OCW-1:0]   out_count_s;
    logic [OW-1:0]    out_head_s, out_push_data_s;
    logic             tag_last_s, accept_s, tag_pop_s, out_push_s, out_pop_s;
    logic             chunk_ready_s, busy_s, done_s, sat_flag_s;
    logic [ACC_W:0]   sat_res_s;
    logic             dp_valid_r;
    logic [8*K-1:0]   dp_mat_r, dp_vec_r;
    logic [K-1:0]     dp_ipv_r;

    // Signed add clamped to the accumulator range; msb flags a clamp.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] == s[ACC_W-1]) begin
            return {1'b0, s[ACC_W-1:0]};
        end else if (s[ACC_W]) begin
            return {1'b1, ACC_MIN};
        end else begin
            return {1'b1, ACC_MAX};
        end
    endfunction

    maple_sync_fifo #(.WIDTH(1), .DEPTH(MAX_INFLIGHT), .CW(TCW)) u_tag_fifo (
        .clk(clk), .rst(rst),
        .push(accept_s), .push_data(chunk_last),
        .pop(tag_pop_s), .pop_data(tag_last_s), .count(tag_count_s)
    );

    maple_sync_fifo #(.WIDTH(OW), .DEPTH(OUT_DEPTH), .CW(OCW)) u_out_fifo (
        .clk(clk), .rst(rst),
        .push(out_push_s), .push_data(out_push_data_s),
        .pop(out_pop_s), .pop_data(out_head_s), .count(out_count_s)
    );

    // Handshake and return-path strobes plus the clamped running sum.
    always_comb begin
        accept_s        = chunk_valid && chunk_ready_s;
        tag_pop_s       = psum_valid && (tag_count_s != {TCW{1'b0}});
        sat_res_s       = sat_add(acc_r, psum);
        sat_flag_s      = sat_r | sat_res_s[ACC_W];
        out_push_s      = tag_pop_s && tag_last_s;
        out_pop_s       = (out_count_s != {OCW{1'b0}}) && row_ready;
        out_push_data_s = {sat_res_s[ACC_W-1:0], ret_row_r, sat_flag_s};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (num_rows == {ROW_W{1'b0}}) ? ST_FINISH : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && chunk_last && ((issue_row_r + ROW_W'(1'b1)) == num_rows_r)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((tag_count_s == {TCW{1'b0}}) && (out_count_s == {OCW{1'b0}}) &&
                    (emit_r == num_rows_r)) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FINISH: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs; a row-ending chunk needs a reserved output slot.
    always_comb begin
        chunk_ready_s = 1'b0;
        busy_s        = (state_r != ST_IDLE);
        done_s        = (state_r == ST_FINISH);
        case (state_r)
            ST_RUN: begin
                if ((tag_count_s < TCW'(MAX_INFLIGHT)) &&
                    (!chunk_last || ((int'(rif_r) + int'(out_count_s)) < OUT_DEPTH))) begin
                    chunk_ready_s = 1'b1;
                end else begin
                    chunk_ready_s = 1'b0;
                end
            end
            default: chunk_ready_s = 1'b0;
        endcase
    end

    // Row counters for issue, return and emit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_rows_r  <= {ROW_W{1'b0}};
            issue_row_r <= {ROW_W{1'b0}};
            ret_row_r   <= {ROW_W{1'b0}};
            emit_r      <= {ROW_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            num_rows_r  <= num_rows;
            issue_row_r <= {ROW_W{1'b0}};
            ret_row_r   <= {ROW_W{1'b0}};
            emit_r      <= {ROW_W{1'b0}};
        end else begin
            if (accept_s && chunk_last) begin
                issue_row_r <= issue_row_r + ROW_W'(1'b1);
            end
            if (out_push_s) begin
                ret_row_r <= ret_row_r + ROW_W'(1'b1);
            end
            if (out_pop_s) begin
                emit_r <= emit_r + ROW_W'(1'b1);
            end
        end
    end

    // Number of row-ending tags currently in the tag FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rif_r <= {TCW{1'b0}};
        end else begin
            case ({accept_s && chunk_last, out_push_s})
                2'b10:   rif_r <= rif_r + TCW'(1'b1);
                2'b01:   rif_r <= rif_r - TCW'(1'b1);
                default: rif_r <= rif_r;
            endcase
        end
    end

    // Per-row accumulator and saturation flag; cleared when a row closes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {ACC_W{1'b0}};
            sat_r <= 1'b0;
        end else if (tag_pop_s) begin
            if (tag_last_s) begin
                acc_r <= {ACC_W{1'b0}};
                sat_r <= 1'b0;
            end else begin
                acc_r <= sat_res_s[ACC_W-1:0];
                sat_r <= sat_flag_s;
            end
        end
    end

    // Sticky error: a partial sum arrived with nothing in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (psum_valid && (tag_count_s == {TCW{1'b0}})) begin
            err_r <= 1'b1;
        end
    end

    // Datapath issue registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_valid_r <= 1'b0;
            dp_mat_r   <= {(8*K){1'b0}};
            dp_vec_r   <= {(8*K){1'b0}};
            dp_ipv_r   <= {K{1'b0}};
        end else begin
            dp_valid_r <= accept_s;
            if (accept_s) begin
                dp_mat_r <= chunk_mat;
                dp_vec_r <= chunk_vec;
                dp_ipv_r <= chunk_ipv;
            end
        end
    end

    assign chunk_ready = chunk_ready_s;
    assign busy        = busy_s;
    assign done        = done_s;
    assign err         = err_r;
    assign dp_valid    = dp_valid_r;
    assign dp_mat      = dp_mat_r;
    assign dp_vec      = dp_vec_r;
    assign dp_ipv      = dp_ipv_r;
    assign row_valid   = (out_count_s != {OCW{1'b0}});
    assign row_data    = out_head_s[OW-1 -: ACC_W];
    assign row_idx     = out_head_s[ROW_W:1];
    assign row_sat     = out_head_s[0];

endmodule

// File: tb/tb_maple_row_scheduler.sv
// Bench for maple_row_scheduler: queue-based reference model checked every
// cycle, a datapath stand-in returning scripted partial sums, and directed
// tests with literal expected row results.
module tb_maple_row_scheduler;

    localparam int K     = 4;
    localparam int ACC_W = 28;
    localparam int ROW_W = 16;
    localparam longint AMAX = (64'sd1 <<< 27) - 64'sd1;
    localparam longint AMIN = -(64'sd1 <<< 27);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [ROW_W-1:0] num_rows = 16'd0;
    logic chunk_valid = 1'b0, chunk_last = 1'b0;
    logic chunk_ready;
    logic [8*K-1:0] chunk_mat = 32'd0, chunk_vec = 32'd0;
    logic [K-1:0] chunk_ipv = 4'd0;
    logic dp_valid;
    logic [8*K-1:0] dp_mat, dp_vec;
    logic [K-1:0] dp_ipv;
    logic psum_valid = 1'b0;
    logic [ACC_W-1:0] psum = 28'd0;
    logic row_valid, row_sat, busy, done, err;
    logic row_ready = 1'b0;
    logic [ACC_W-1:0] row_data;
    logic [ROW_W-1:0] row_idx;

    maple_row_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready),
        .chunk_mat(chunk_mat), .chunk_vec(chunk_vec), .chunk_ipv(chunk_ipv),
        .chunk_last(chunk_last), .dp_valid(dp_valid), .dp_mat(dp_mat),
        .dp_vec(dp_vec), .dp_ipv(dp_ipv), .psum_valid(psum_valid), .psum(psum),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .row_sat(row_sat), .busy(busy), .done(done), .err(err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    typedef struct {
        longint data;
        int     idx;
        bit     sat;
    } row_t;

    // Reference model state.
    bit          tag_q[$];
    row_t        out_q[$];
    longint      m_acc;
    bit          m_sat, m_err, m_open, m_dpv;
    int          m_ret, m_rows, m_issued;
    logic [31:0] m_mat, m_vec;
    logic [3:0]  m_ipv;

    function automatic bit model_ready(input bit last);
        int rows;
        rows = 0;
        foreach (tag_q[i]) if (tag_q[i]) rows++;
        return m_open && (tag_q.size() < 4) && (!last || (rows + out_q.size()) < 2);
    endfunction

    // Reference model update at each clock edge (async reset).
    always @(posedge clk or negedge rst) begin
        bit acc_ok, lt, satf;
        longint s;
        if (!rst) begin
            tag_q.delete(); out_q.delete();
            m_acc = 0; m_sat = 0; m_err = 0; m_open = 0; m_dpv = 0;
            m_ret = 0; m_rows = 0; m_issued = 0;
            m_mat = 32'd0; m_vec = 32'd0; m_ipv = 4'd0;
        end else begin
            acc_ok = chunk_valid && model_ready(chunk_last);
            if (out_q.size() > 0 && row_ready) void'(out_q.pop_front());
            if (psum_valid) begin
                if (tag_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    lt   = tag_q.pop_front();
                    s    = m_acc + longint'($signed(psum));
                    satf = m_sat;
                    if (s > AMAX) begin s = AMAX; satf = 1; end
                    else if (s < AMIN) begin s = AMIN; satf = 1; end
                    if (lt) begin
                        out_q.push_back(row_t'{s, m_ret, satf});
                        m_ret++; m_acc = 0; m_sat = 0;
                    end else begin
                        m_acc = s; m_sat = satf;
                    end
                end
            end
            if (acc_ok) begin
                tag_q.push_back(chunk_last);
                m_mat = chunk_mat; m_vec = chunk_vec; m_ipv = chunk_ipv; m_dpv = 1;
                if (chunk_last) begin
                    m_issued++;
                    if (m_issued == m_rows) m_open = 0;
                end
            end else begin
                m_dpv = 0;
            end
            if (start) begin
                m_rows = num_rows; m_issued = 0; m_ret = 0; m_open = (num_rows != 16'd0);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("chunk_ready", chunk_ready, model_ready(chunk_last));
            chk("dp_valid", dp_valid, m_dpv);
            if (m_dpv) begin
                chk("dp_mat", dp_mat, m_mat);
                chk("dp_vec", dp_vec, m_vec);
                chk("dp_ipv", dp_ipv, m_ipv);
            end
            chk("row_valid", row_valid, out_q.size() > 0);
            if (out_q.size() > 0) begin
                chk("row_data", $signed(row_data), out_q[0].data);
                chk("row_idx", row_idx, out_q[0].idx);
                chk("row_sat", row_sat, out_q[0].sat);
            end
            chk("err", err, m_err);
        end
    end

    // Datapath stand-in: scripted psum per issued chunk, returned in order.
    longint     tab_q[$];
    logic [27:0] pend[$];
    bit         hold = 0, man_pulse = 0;
    logic [27:0] man_psum = 28'd0;
    row_t       log_q[$];

    // Record each issued chunk's scripted partial sum.
    always @(negedge clk) begin
        if (rst && dp_valid) begin
            if (tab_q.size() > 0) pend.push_back(28'(tab_q.pop_front()));
            else pend.push_back(28'd0);
        end
    end

    // Log every row result accepted by the consumer.
    always @(negedge clk) begin
        if (rst && row_valid && row_ready)
            log_q.push_back(row_t'{longint'($signed(row_data)), int'(row_idx), row_sat});
    end

    // Drive partial sums back, unless held.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (man_pulse) begin
                psum_valid = 1'b1; psum = man_psum; man_pulse = 0;
            end else if (!hold && pend.size() > 0) begin
                psum_valid = 1'b1; psum = pend.pop_front();
            end else begin
                psum_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int n);
        num_rows = 16'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_chunk(input int i, input bit last, input logic [3:0] ipv);
        chunk_mat = 32'h10203040 + 32'(i);
        chunk_vec = 32'h0A0B0C0D ^ 32'(i);
        chunk_ipv = ipv; chunk_last = last;
    endtask

    task automatic send_chunk(input int i, input bit last, input logic [3:0] ipv);
        bit ok;
        ok = 0;
        chunk_valid = 1'b1;
        set_chunk(i, last, ipv);
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk); ok = chunk_ready;
            tick();
        end
        chunk_valid = 1'b0; chunk_last = 1'b0;
        chk("chunk_accept", ok, 1);
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        chk(name, got, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        tick();
    endtask

    task automatic chk_row(input string name, input int n, input longint d, input int idx, input bit sat);
        if (log_q.size() > n) begin
            chk({name, "_data"}, log_q[n].data, d);
            chk({name, "_idx"}, log_q[n].idx, idx);
            chk({name, "_sat"}, log_q[n].sat, sat);
        end else begin
            chk({name, "_present"}, 0, 1);
        end
    endtask

    // Directed test sequence.
    initial begin
        int k, issued;
        bit a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_chunk_ready", chunk_ready, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b1;
        tick();

        // One row from two chunks: 10 + -3.
        log_q.delete(); tab_q = '{10, -3}; row_ready = 1'b1;
        do_start(1);
        @(negedge clk); chk("t1_busy", busy, 1); tick();
        send_chunk(0, 0, 4'hF);
        send_chunk(1, 1, 4'h3);
        wait_done("t1_done");
        chk("t1_rows", log_q.size(), 1);
        chk_row("t1_r0", 0, 7, 0, 0);

        // Three one-chunk rows with consumer stalled; output slots limit issue.
        log_q.delete(); tab_q = '{5, 0, -8}; row_ready = 1'b0;
        do_start(3);
        send_chunk(0, 1, 4'hF);
        send_chunk(1, 1, 4'h0);
        chunk_valid = 1'b1; set_chunk(2, 1, 4'h5);
        repeat (8) begin
            @(negedge clk); chk("t2_blocked", chunk_ready, 0); tick();
        end
        @(negedge clk); chk("t2_row_valid", row_valid, 1); tick();
        chk("t2_none_yet", log_q.size(), 0);
        row_ready = 1'b1;
        send_chunk(2, 1, 4'h5);
        wait_done("t2_done");
        chk("t2_rows", log_q.size(), 3);
        chk_row("t2_r0", 0, 5, 0, 0);
        chk_row("t2_r1", 1, 0, 1, 0);
        chk_row("t2_r2", 2, -8, 2, 0);

        // Positive saturation, flag cleared for the next row.
        log_q.delete(); tab_q = '{134217727, 1, 4};
        do_start(2);
        send_chunk(0, 0, 4'h1);
        send_chunk(1, 1, 4'h2);
        send_chunk(2, 1, 4'h4);
        wait_done("t3_done");
        chk("t3_rows", log_q.size(), 2);
        chk_row("t3_r0", 0, 134217727, 0, 1);
        chk_row("t3_r1", 1, 4, 1, 0);

        // In-flight limit: six chunks offered, datapath holding results.
        log_q.delete(); tab_q = '{1, 1, 1, 1, 1, 1}; hold = 1;
        do_start(1);
        k = 0; issued = 0;
        chunk_valid = 1'b1; set_chunk(k, k == 5, 4'hF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); a = chunk_ready;
            if (a) issued++;
            tick();
            if (a) begin k++; set_chunk(k, k == 5, 4'hF); end
        end
        chk("t4_issued", issued, 4);
        hold = 0;
        send_chunk(4, 0, 4'hF);
        send_chunk(5, 1, 4'hF);
        wait_done("t4_done");
        chk("t4_rows", log_q.size(), 1);
        chk_row("t4_r0", 0, 6, 0, 0);

        // Stray partial sum while idle.
        log_q.delete();
        @(negedge clk); chk("t5_err_before", err, 0); tick();
        man_psum = 28'd5; man_pulse = 1;
        repeat (3) tick();
        @(negedge clk);
        chk("t5_err_set", err, 1);
        chk("t5_no_row", row_valid, 0);
        tick();
        repeat (5) tick();
        @(negedge clk); chk("t5_err_sticky", err, 1); tick();
        chk("t5_rows", log_q.size(), 0);

        // Reset with three chunks in flight.
        tab_q = '{1, 1, 1}; hold = 1;
        do_start(2);
        send_chunk(0, 0, 4'hF);
        send_chunk(1, 0, 4'hF);
        send_chunk(2, 0, 4'hF);
        #2 rst = 1'b0;
        #1;
        chk("t6_chunk_ready", chunk_ready, 0);
        chk("t6_dp_valid", dp_valid, 0);
        chk("t6_dp_mat", dp_mat, 0);
        chk("t6_dp_vec", dp_vec, 0);
        chk("t6_dp_ipv", dp_ipv, 0);
        chk("t6_row_valid", row_valid, 0);
        chk("t6_row_data", row_data, 0);
        chk("t6_row_idx", row_idx, 0);
        chk("t6_row_sat", row_sat, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        pend.delete(); tab_q.delete(); hold = 0;
        tick();
        rst = 1'b1;
        tick();
        log_q.delete(); tab_q = '{9};
        do_start(1);
        send_chunk(0, 1, 4'h8);
        wait_done("t6_done_after");
        chk("t6_rows", log_q.size(), 1);
        chk_row("t6_r0", 0, 9, 0, 0);

        // Zero-row matrix finishes at once.
        log_q.delete();
        do_start(0);
        wait_done("t7_done");
        chk("t7_rows", log_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1);
    end

endmodule
